imem_boot_loader: RTL

//  Byte-stream boot loader that writes the program into the byte-wide, big-endian instruction memory.
//  The pipeline core only reads this memory; this block is the writer side of that interface.
//  It holds the core in reset until a complete program has been loaded and its checksum verified.
//  It sits between an external byte source (valid/ready) and the instruction-memory write port.

---
 rtl/imem_boot_loader_if.sv | 31 +++
 rtl/imem_boot_loader.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader_if.sv
// rtl/imem_boot_loader_if.sv - byte stream in and instruction-memory write port of the boot loader
interface imem_boot_loader_if #(
    parameter int ADDR_W = 7
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    // Byte source and memory observer side
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    // Loader side
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - framed byte-stream loader for the instruction memory with XOR check
module imem_boot_loader #(
    parameter int MEM_DEPTH = 101,
    parameter int ADDR_W    = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    imem_boot_loader_if.slave   bus,
    output logic                cpu_reset,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [1:0]          err_code
);
    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR
    } state_t;

    state_t            state, state_n;
    logic [15:0]       len, len_n;
    logic [15:0]       count, count_n;
    logic [7:0]        csum, csum_n;
    logic              in_ready_n, mem_we_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [7:0]        mem_wdata_n;
    logic              cpu_reset_n, busy_n, done_n, err_n;
    logic [1:0]        err_code_n;
    logic              hs;

    assign hs = bus.in_valid && bus.in_ready;

    // Register the state and every output so the core and memory see glitch-free signals
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            len           <= '0;
            count         <= '0;
            csum          <= '0;
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            cpu_reset     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            err_code      <= 2'b00;
        end else begin
            state         <= state_n;
            len           <= len_n;
            count         <= count_n;
            csum          <= csum_n;
            bus.in_ready  <= in_ready_n;
            bus.mem_we    <= mem_we_n;
            bus.mem_addr  <= mem_addr_n;
            bus.mem_wdata <= mem_wdata_n;
            cpu_reset     <= cpu_reset_n;
            busy          <= busy_n;
            done          <= done_n;
            err           <= err_n;
            err_code      <= err_code_n;
        end
    end

    // Next-state and next-output logic; the write strobe defaults low so it pulses once per byte
    always_comb begin
        state_n     = state;
        len_n       = len;
        count_n     = count;
        csum_n      = csum;
        mem_we_n    = 1'b0;
        mem_addr_n  = bus.mem_addr;
        mem_wdata_n = bus.mem_wdata;
        cpu_reset_n = cpu_reset;
        busy_n      = busy;
        done_n      = done;
        err_n       = err;
        err_code_n  = err_code;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = LEN_HI;
                    busy_n  = 1'b1;
                end
            end
            LEN_HI: begin
                if (hs) begin
                    len_n[15:8] = bus.in_data;
                    state_n     = LEN_LO;
                end
            end
            LEN_LO: begin
                if (hs) begin
                    len_n = {len[15:8], bus.in_data};
                    if (len_n == 16'd0 || len_n > 16'(MEM_DEPTH)) begin
                        state_n    = ERR;
                        busy_n     = 1'b0;
                        err_n      = 1'b1;
                        err_code_n = 2'b01;
                    end else if (len_n[1:0] != 2'b00) begin
                        state_n    = ERR;
                        busy_n     = 1'b0;
                        err_n      = 1'b1;
                        err_code_n = 2'b11;
                    end else begin
                        state_n = DATA;
                        count_n = '0;
                        csum_n  = '0;
                    end
                end
            end
            DATA: begin
                if (hs) begin
                    csum_n      = csum ^ bus.in_data;
                    count_n     = count + 16'd1;
                    mem_we_n    = 1'b1;
                    mem_addr_n  = count[ADDR_W-1:0];
                    mem_wdata_n = bus.in_data;
                    if (count_n == len) state_n = CSUM;
                end
            end
            CSUM: begin
                if (hs) begin
                    busy_n = 1'b0;
                    if (bus.in_data == csum) begin
                        state_n     = DONE;
                        done_n      = 1'b1;
                        cpu_reset_n = 1'b1;
                    end else begin
                        state_n    = ERR;
                        err_n      = 1'b1;
                        err_code_n = 2'b10;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_n     = LEN_HI;
                    done_n      = 1'b0;
                    cpu_reset_n = 1'b0;
                    busy_n      = 1'b1;
                end
            end
            ERR: begin
                if (start) begin
                    state_n    = LEN_HI;
                    err_n      = 1'b0;
                    err_code_n = 2'b00;
                    busy_n     = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        in_ready_n = (state_n == LEN_HI) || (state_n == LEN_LO) ||
                     (state_n == DATA)   || (state_n == CSUM);
    end
endmodule
